target_motion_predictor: RTL and testbench
==========================================

// Module: target_motion_predictor
// PURPOSE
//  Per-frame lead predictor between the pixel mixer's final target coordinate and the SPI slave.
//  Tracks target velocity with a first-order filter and extrapolates LEAD_FRAMES ahead
//    so the STM motor loop aims where the target will be.
//  Coasts through short detection dropouts; drives track_active as the virtual red_detected bit in miso_etc.
// PARAMETERS
//  X_MAX        319  max legal x coordinate (inclusive)
//  Y_MAX        239  max legal y coordinate (inclusive)
//  VEL_SHIFT    2    filter gain: v += (d - v) >>> VEL_SHIFT; 0 = raw difference
//  V_FRAC       4    fractional bits of internal velocity
//  LEAD_FRAMES  2    frames of extrapolation, 0..7
//  COAST_FRAMES 5    missed frames tolerated before dropping track, 1..15
//  MAX_JUMP     64   |dx| or |dy| above this is a new target (re-acquire)
// PORTS
//  clk           in   1   system clock; single clock domain
//  reset         in   1   synchronous, active-high
//  meas_valid    in   1   one-cycle strobe, once per frame (after v_sync)
//  meas_detected in   1   target present this frame; sampled with meas_valid
//  meas_x        in   10  measured x; sampled with meas_valid
//  meas_y        in   10  measured y; sampled with meas_valid
//  pred_x        out  10  predicted x, clamped 0..X_MAX
//  pred_y        out  9   predicted y, clamped 0..Y_MAX
//  pred_valid    out  1   one-cycle pulse when pred_x/pred_y update
//  track_active  out  1   1 in TRACK/COAST (and ACQ after a valid sample)
// BEHAVIOUR
//  Reset: state=IDLE; pred_x=pred_y=0; pred_valid=0; track_active=0; vx=vy=0; miss_cnt=0.
//  Inputs act only on meas_valid; other cycles hold all state.
//  Latency: pred_* and pred_valid update exactly 2 clk after the meas_valid cycle.
//    S1 = difference + filter. S2 = extrapolate + clamp.
//  A meas_valid arriving while S1/S2 are busy (spacing <3 clk) is unsupported; one strobe per frame is guaranteed.
//  FSM:
//   IDLE : detected -> ACQ; store pos=meas; v=0; pred=meas.
//          miss -> stay; outputs hold; no pred_valid.
//   ACQ  : detected, |d|<=MAX_JUMP -> TRACK; v = d<<V_FRAC (unfiltered seed).
//          detected, jump -> stay ACQ; pos=meas; v=0.
//          miss -> IDLE.
//   TRACK: detected, no jump -> TRACK; v += ((d<<V_FRAC) - v) >>> VEL_SHIFT; miss_cnt=0.
//          detected, jump -> ACQ; pos=meas; v=0; pred=meas.
//          miss -> COAST; miss_cnt=1; pos += v>>>V_FRAC.
//   COAST: detected, no jump vs coasted pos -> TRACK; filter update as in TRACK; miss_cnt=0.
//          detected, jump -> ACQ.
//          miss, miss_cnt<COAST_FRAMES -> pos += v>>>V_FRAC; miss_cnt++.
//          miss, miss_cnt==COAST_FRAMES -> IDLE; v=0; pred holds its last value.
//  d = meas - pos: signed 11 bit. v: signed 16 bit, Q(11.V_FRAC), saturating.
//  Jump test: |dx|>MAX_JUMP OR |dy|>MAX_JUMP (either axis).
//  pred = pos + ((v*LEAD_FRAMES) >>> V_FRAC), computed signed 14 bit.
//    Clamp: <0 -> 0; >MAX -> MAX. Coasted pos is clamped identically.
//  pred_valid pulses on every meas_valid except misses while in IDLE.
//  track_active: registered with the S2 output, same cycle as pred_valid.
//  Reset mid-pipeline: S1/S2 contents are discarded; no pred_valid is emitted after reset.
// STRUCTURE
//  target_pkg: track_state_t {IDLE,ACQ,TRACK,COAST}; COORD_W=10; VEL_W=16.
//  Sub-module axis_lead_filter (instantiated x2: x and y): pos/v registers, diff, filter, extrapolate, clamp.
//    Parameter AXIS_MAX. Returns |d|>MAX_JUMP to the parent.
//  Parent: FSM, miss_cnt, jump OR, pred_valid/track_active pipeline.
// TESTING (VEL_SHIFT=0, V_FRAC=4, LEAD=2, COAST=5, MAX_JUMP=64 unless stated)
//  Constant motion: x=100,110,120,130 detected, y=50 fixed -> pred_x=100,130,140,150 (first via ACQ seed); pred_y=50.
//    pred_valid exactly 2 clk after each strobe.
//  Edge clamp: x=300,310 -> pred_x=319, not 330. Leftward x=10,2 -> pred_x=0, no wrap.
//  Dropout: track at v=+10 from x=150, then 3 misses then hit x=190 -> COAST pred 170,180,190, then TRACK.
//    6 misses -> IDLE at 6th, track_active=0, pred holds.
//  Jump: TRACK at x=50, next meas x=200 -> state ACQ, v=0, pred_x=200, track_active=1.
//  Filter gain: VEL_SHIFT=2, v=0 seed then steady d=+8 -> v converges 2,3.5,4.6..., pred lags raw, no overshoot.
//  Reset asserted 1 clk after meas_valid -> no pred_valid; all outputs 0; next detect enters ACQ.

Source files
------------

// File: rtl/target_pkg.sv
// Shared types and helpers for the target lead predictor.
package target_pkg;

  localparam int COORD_W = 10;
  localparam int VEL_W   = 16;
  localparam int DIFF_W  = 11;
  localparam int MISS_W  = 4;
  localparam int WIDE_W  = 22;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    TRACK,
    COAST
  } track_state_t;

  // Per-axis update selected by the parent FSM on a measurement strobe.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_SEED,
    OP_FILT,
    OP_COAST,
    OP_DROP
  } axis_op_t;

  localparam logic signed [WIDE_W-1:0] VEL_POS_LIM = 22'sd32767;
  localparam logic signed [WIDE_W-1:0] VEL_NEG_LIM = -22'sd32768;

  function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [WIDE_W-1:0] a);
    if (a > VEL_POS_LIM) return VEL_POS_LIM[VEL_W-1:0];
    if (a < VEL_NEG_LIM) return VEL_NEG_LIM[VEL_W-1:0];
    return VEL_W'(a);
  endfunction

  function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [WIDE_W-1:0] a,
                                                     input logic signed [WIDE_W-1:0] max_val);
    if (a < 0) return '0;
    if (a > max_val) return COORD_W'(max_val);
    return COORD_W'(a);
  endfunction

endpackage

// File: rtl/axis_lead_filter.sv
// One axis of the lead predictor: position/velocity state, difference, velocity
// filter, coast step, and lead extrapolation with clamp to 0..AXIS_MAX.
module axis_lead_filter
  import target_pkg::*;
#(
  parameter int AXIS_MAX    = 319,
  parameter int OUT_W       = 10,
  parameter int VEL_SHIFT   = 2,
  parameter int V_FRAC      = 4,
  parameter int LEAD_FRAMES = 2,
  parameter int MAX_JUMP    = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_s1_en,
  input  axis_op_t           i_op,
  input  logic [COORD_W-1:0] i_meas,
  input  logic               i_s2_en,
  input  logic               i_s2_hold,
  output logic               o_jump,
  output logic [OUT_W-1:0]   o_pred
);

  logic [COORD_W-1:0]       r_pos;
  logic signed [VEL_W-1:0]  r_vel;
  logic [OUT_W-1:0]         r_pred;

  logic signed [DIFF_W-1:0] w_diff;
  logic [DIFF_W-1:0]        w_abs;
  logic signed [WIDE_W-1:0] w_vel_wide;
  logic signed [WIDE_W-1:0] w_pos_wide;
  logic signed [WIDE_W-1:0] w_dq;
  logic signed [WIDE_W-1:0] w_err;
  logic signed [WIDE_W-1:0] w_filt;
  logic signed [WIDE_W-1:0] w_step;
  logic signed [WIDE_W-1:0] w_lead;
  logic signed [VEL_W-1:0]  w_seed;
  logic signed [VEL_W-1:0]  w_vel_filt;
  logic [COORD_W-1:0]       w_pos_coast;
  logic [COORD_W-1:0]       w_pred_clamp;

  always_comb begin
    w_diff       = $signed({1'b0, i_meas}) - $signed({1'b0, r_pos});
    w_abs        = w_diff[DIFF_W-1] ? DIFF_W'(-w_diff) : DIFF_W'(w_diff);
    o_jump       = (w_abs > DIFF_W'(MAX_JUMP));

    w_vel_wide   = WIDE_W'(r_vel);
    w_pos_wide   = WIDE_W'($signed({1'b0, r_pos}));
    w_dq         = WIDE_W'(w_diff) <<< V_FRAC;
    w_err        = w_dq - w_vel_wide;
    w_filt       = w_vel_wide + (w_err >>> VEL_SHIFT);
    w_seed       = sat_vel(w_dq);
    w_vel_filt   = sat_vel(w_filt);

    // Coasting advances by the integer part of the velocity each missed frame.
    w_step       = w_vel_wide >>> V_FRAC;
    w_pos_coast  = clamp_coord(w_pos_wide + w_step, WIDE_W'(AXIS_MAX));

    w_lead       = (w_vel_wide * WIDE_W'(LEAD_FRAMES)) >>> V_FRAC;
    w_pred_clamp = clamp_coord(w_pos_wide + w_lead, WIDE_W'(AXIS_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos  <= '0;
      r_vel  <= '0;
      r_pred <= '0;
    end else begin
      if (i_s1_en) begin
        unique case (i_op)
          OP_LOAD: begin
            r_pos <= i_meas;
            r_vel <= '0;
          end
          OP_SEED: begin
            r_pos <= i_meas;
            r_vel <= w_seed;
          end
          OP_FILT: begin
            r_pos <= i_meas;
            r_vel <= w_vel_filt;
          end
          OP_COAST: r_pos <= w_pos_coast;
          OP_DROP:  r_vel <= '0;
          default: ;
        endcase
      end
      if (i_s2_en && !i_s2_hold) begin
        r_pred <= OUT_W'(w_pred_clamp);
      end
    end
  end

  assign o_pred = r_pred;

endmodule

// File: rtl/target_motion_predictor.sv
// Per-frame target lead predictor: tracking FSM, dropout coasting and a
// two-stage (filter, then extrapolate/clamp) pipeline per axis.
//
// state | meaning
// IDLE  | no target; misses are ignored, outputs hold
// ACQ   | one sample held, velocity zero, waiting for a consistent second hit
// TRACK | filtered velocity valid, following measurements
// COAST | target missing, dead-reckoning on last velocity up to COAST_FRAMES
module target_motion_predictor
  import target_pkg::*;
#(
  parameter int X_MAX        = 319,
  parameter int Y_MAX        = 239,
  parameter int VEL_SHIFT    = 2,
  parameter int V_FRAC       = 4,
  parameter int LEAD_FRAMES  = 2,
  parameter int COAST_FRAMES = 5,
  parameter int MAX_JUMP     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        meas_valid,
  input  logic        meas_detected,
  input  logic [9:0]  meas_x,
  input  logic [9:0]  meas_y,
  output logic [9:0]  pred_x,
  output logic [8:0]  pred_y,
  output logic        pred_valid,
  output logic        track_active
);

  track_state_t      r_state;
  logic [MISS_W-1:0] r_miss_cnt;
  logic              r_s2_pend;
  logic              r_s2_hold;
  logic              r_s2_active;
  logic              r_pred_valid;
  logic              r_track_active;

  track_state_t      w_next_state;
  axis_op_t          w_op;
  logic [MISS_W-1:0] w_cnt_next;
  logic              w_hold;
  logic              w_emit;
  logic              w_jump_x;
  logic              w_jump_y;
  logic              w_jump;

  assign w_jump = w_jump_x | w_jump_y;

  always_comb begin
    w_next_state = r_state;
    w_op         = OP_HOLD;
    w_cnt_next   = r_miss_cnt;
    w_hold       = 1'b0;
    w_emit       = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (meas_detected) begin
          w_next_state = ACQ;
          w_op         = OP_LOAD;
        end else begin
          w_emit = 1'b0;
        end
      end
      ACQ: begin
        if (!meas_detected) begin
          w_next_state = IDLE;
          w_op         = OP_DROP;
          w_hold       = 1'b1;
        end else if (w_jump) begin
          w_op = OP_LOAD;
        end else begin
          w_next_state = TRACK;
          w_op         = OP_SEED;
        end
      end
      TRACK: begin
        if (!meas_detected) begin
          w_next_state = COAST;
          w_op         = OP_COAST;
          w_cnt_next   = MISS_W'(1);
        end else if (w_jump) begin
          w_next_state = ACQ;
          w_op         = OP_LOAD;
        end else begin
          w_op       = OP_FILT;
          w_cnt_next = '0;
        end
      end
      COAST: begin
        if (!meas_detected) begin
          if (r_miss_cnt < MISS_W'(COAST_FRAMES)) begin
            w_op       = OP_COAST;
            w_cnt_next = r_miss_cnt + 1'b1;
          end else begin
            // Track lost: prediction keeps the last coasted value.
            w_next_state = IDLE;
            w_op         = OP_DROP;
            w_hold       = 1'b1;
            w_cnt_next   = '0;
          end
        end else if (w_jump) begin
          w_next_state = ACQ;
          w_op         = OP_LOAD;
          w_cnt_next   = '0;
        end else begin
          w_next_state = TRACK;
          w_op         = OP_FILT;
          w_cnt_next   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_miss_cnt     <= '0;
      r_s2_pend      <= 1'b0;
      r_s2_hold      <= 1'b0;
      r_s2_active    <= 1'b0;
      r_pred_valid   <= 1'b0;
      r_track_active <= 1'b0;
    end else begin
      r_s2_pend <= 1'b0;
      if (meas_valid) begin
        r_state     <= w_next_state;
        r_miss_cnt  <= w_cnt_next;
        r_s2_pend   <= w_emit;
        r_s2_hold   <= w_hold;
        r_s2_active <= (w_next_state != IDLE);
      end
      r_pred_valid <= r_s2_pend;
      if (r_s2_pend) begin
        r_track_active <= r_s2_active;
      end
    end
  end

  axis_lead_filter #(
    .AXIS_MAX    (X_MAX),
    .OUT_W       (10),
    .VEL_SHIFT   (VEL_SHIFT),
    .V_FRAC      (V_FRAC),
    .LEAD_FRAMES (LEAD_FRAMES),
    .MAX_JUMP    (MAX_JUMP)
  ) u_axis_x (
    .clk       (clk),
    .reset     (reset),
    .i_s1_en   (meas_valid),
    .i_op      (w_op),
    .i_meas    (meas_x),
    .i_s2_en   (r_s2_pend),
    .i_s2_hold (r_s2_hold),
    .o_jump    (w_jump_x),
    .o_pred    (pred_x)
  );

  axis_lead_filter #(
    .AXIS_MAX    (Y_MAX),
    .OUT_W       (9),
    .VEL_SHIFT   (VEL_SHIFT),
    .V_FRAC      (V_FRAC),
    .LEAD_FRAMES (LEAD_FRAMES),
    .MAX_JUMP    (MAX_JUMP)
  ) u_axis_y (
    .clk       (clk),
    .reset     (reset),
    .i_s1_en   (meas_valid),
    .i_op      (w_op),
    .i_meas    (meas_y),
    .i_s2_en   (r_s2_pend),
    .i_s2_hold (r_s2_hold),
    .o_jump    (w_jump_y),
    .o_pred    (pred_y)
  );

  assign pred_valid   = r_pred_valid;
  assign track_active = r_track_active;

endmodule

// File: tb/tb_target_motion_predictor.sv
// Directed bench: raw-difference instance (VEL_SHIFT=0) for tracking, clamp,
// dropout, jump and reset cases; VEL_SHIFT=2 instance for the filter gain case.
module tb_target_motion_predictor;

  logic       clk = 1'b0;
  logic       reset;
  logic       meas_valid;
  logic       meas_detected;
  logic [9:0] meas_x;
  logic [9:0] meas_y;

  logic [9:0] px0, px1;
  logic [8:0] py0, py1;
  logic       pv0, pv1;
  logic       ta0, ta1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  target_motion_predictor #(.VEL_SHIFT(0)) dut_raw (
    .clk           (clk),
    .reset         (reset),
    .meas_valid    (meas_valid),
    .meas_detected (meas_detected),
    .meas_x        (meas_x),
    .meas_y        (meas_y),
    .pred_x        (px0),
    .pred_y        (py0),
    .pred_valid    (pv0),
    .track_active  (ta0)
  );

  target_motion_predictor #(.VEL_SHIFT(2)) dut_filt (
    .clk           (clk),
    .reset         (reset),
    .meas_valid    (meas_valid),
    .meas_detected (meas_detected),
    .meas_x        (meas_x),
    .meas_y        (meas_y),
    .pred_x        (px1),
    .pred_y        (py1),
    .pred_valid    (pv1),
    .track_active  (ta1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One strobe, then check the 2-cycle latency and one-cycle pulse width.
  task automatic do_meas(input string tag, input int sel, input logic det,
                         input int x, input int y, input logic exp_pv,
                         input int exp_x, input int exp_y, input logic exp_act);
    @(negedge clk);
    meas_valid    = 1'b1;
    meas_detected = det;
    meas_x        = 10'(x);
    meas_y        = 10'(y);
    @(negedge clk);
    meas_valid    = 1'b0;
    meas_detected = 1'b0;
    check_val({tag, "_pv_early"}, 32'(sel != 0 ? pv1 : pv0), 32'(0));
    @(negedge clk);
    check_val({tag, "_pv"},  32'(sel != 0 ? pv1 : pv0), 32'(exp_pv));
    check_val({tag, "_x"},   32'(sel != 0 ? px1 : px0), 32'(exp_x));
    check_val({tag, "_y"},   32'(sel != 0 ? py1 : py0), 32'(exp_y));
    check_val({tag, "_act"}, 32'(sel != 0 ? ta1 : ta0), 32'(exp_act));
    @(negedge clk);
    check_val({tag, "_pv_end"}, 32'(sel != 0 ? pv1 : pv0), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    meas_valid    = 1'b0;
    meas_detected = 1'b0;
    meas_x        = '0;
    meas_y        = '0;
    do_reset();
    check_val("rst_x",   32'(px0), 32'(0));
    check_val("rst_y",   32'(py0), 32'(0));
    check_val("rst_pv",  32'(pv0), 32'(0));
    check_val("rst_act", 32'(ta0), 32'(0));
    check_val("rst_act_f", 32'(ta1), 32'(0));

    // Miss in IDLE emits nothing.
    do_meas("idle_miss", 0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);

    // Constant motion: ACQ seed then lead of 2 frames at v=10.
    do_meas("cm0", 0, 1'b1, 100, 50, 1'b1, 100, 50, 1'b1);
    do_meas("cm1", 0, 1'b1, 110, 50, 1'b1, 130, 50, 1'b1);
    do_meas("cm2", 0, 1'b1, 120, 50, 1'b1, 140, 50, 1'b1);
    do_meas("cm3", 0, 1'b1, 130, 50, 1'b1, 150, 50, 1'b1);

    // Jump from TRACK re-acquires with v=0.
    do_reset();
    do_meas("jp0", 0, 1'b1, 40,  50, 1'b1, 40,  50, 1'b1);
    do_meas("jp1", 0, 1'b1, 50,  50, 1'b1, 70,  50, 1'b1);
    do_meas("jp2", 0, 1'b1, 200, 50, 1'b1, 200, 50, 1'b1);
    do_meas("jp3", 0, 1'b1, 205, 50, 1'b1, 215, 50, 1'b1);

    // Clamp at high edges and at zero.
    do_reset();
    do_meas("hi0", 0, 1'b1, 300, 230, 1'b1, 300, 230, 1'b1);
    do_meas("hi1", 0, 1'b1, 310, 238, 1'b1, 319, 239, 1'b1);
    do_reset();
    do_meas("lo0", 0, 1'b1, 10, 50, 1'b1, 10, 50, 1'b1);
    do_meas("lo1", 0, 1'b1, 2,  50, 1'b1, 0,  50, 1'b1);

    // Dropout: coast 3 frames, recover, then lose the track after 6 misses.
    do_reset();
    do_meas("dr0", 0, 1'b1, 120, 50, 1'b1, 120, 50, 1'b1);
    do_meas("dr1", 0, 1'b1, 130, 50, 1'b1, 150, 50, 1'b1);
    do_meas("dr2", 0, 1'b1, 140, 50, 1'b1, 160, 50, 1'b1);
    do_meas("co1", 0, 1'b0, 0, 0, 1'b1, 170, 50, 1'b1);
    do_meas("co2", 0, 1'b0, 0, 0, 1'b1, 180, 50, 1'b1);
    do_meas("co3", 0, 1'b0, 0, 0, 1'b1, 190, 50, 1'b1);
    do_meas("rehit", 0, 1'b1, 190, 50, 1'b1, 230, 50, 1'b1);
    do_meas("ms1", 0, 1'b0, 0, 0, 1'b1, 250, 50, 1'b1);
    do_meas("ms2", 0, 1'b0, 0, 0, 1'b1, 270, 50, 1'b1);
    do_meas("ms3", 0, 1'b0, 0, 0, 1'b1, 290, 50, 1'b1);
    do_meas("ms4", 0, 1'b0, 0, 0, 1'b1, 310, 50, 1'b1);
    do_meas("ms5", 0, 1'b0, 0, 0, 1'b1, 319, 50, 1'b1);
    do_meas("ms6", 0, 1'b0, 0, 0, 1'b1, 319, 50, 1'b0);
    do_meas("ms7", 0, 1'b0, 0, 0, 1'b0, 319, 50, 1'b0);

    // Reset one clock after the strobe discards the pipeline.
    @(negedge clk);
    meas_valid    = 1'b1;
    meas_detected = 1'b1;
    meas_x        = 10'd100;
    meas_y        = 10'd60;
    @(negedge clk);
    meas_valid    = 1'b0;
    meas_detected = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("mid_pv",  32'(pv0), 32'(0));
    check_val("mid_x",   32'(px0), 32'(0));
    check_val("mid_y",   32'(py0), 32'(0));
    check_val("mid_act", 32'(ta0), 32'(0));
    @(negedge clk);
    check_val("mid_pv2", 32'(pv0), 32'(0));
    do_meas("mid_acq", 0, 1'b1, 77, 60, 1'b1, 77, 60, 1'b1);
    do_meas("mid_trk", 0, 1'b1, 80, 60, 1'b1, 86, 60, 1'b1);

    // Filter gain 1/4: v = 0, 2, 3.5, 4.625, 5.4375 px/frame.
    do_reset();
    do_meas("fg0", 1, 1'b1, 100, 50, 1'b1, 100, 50, 1'b1);
    do_meas("fg1", 1, 1'b1, 100, 50, 1'b1, 100, 50, 1'b1);
    do_meas("fg2", 1, 1'b1, 108, 50, 1'b1, 112, 50, 1'b1);
    do_meas("fg3", 1, 1'b1, 116, 50, 1'b1, 123, 50, 1'b1);
    do_meas("fg4", 1, 1'b1, 124, 50, 1'b1, 133, 50, 1'b1);
    do_meas("fg5", 1, 1'b1, 132, 50, 1'b1, 142, 50, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
